// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared UART types and defaults for the TX and RX paths
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Defaults live here so both directions agree on the bit period.
    localparam int   UART_BAUD_DIV  = 2000;
    localparam int   UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
//------------------------------------------------------------------------------
// uart_tx_bit_timer : reloadable per-bit down-counter, expires once per BAUD_DIV
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_bit_timer #(
    parameter int BAUD_DIV = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int               CNT_W  = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = RELOAD;
        end else if (en_i) begin
            count_d = (count_q == '0) ? RELOAD : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// uart_tx : 8N1-style UART transmitter with valid/ready byte input
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = UART_BAUD_DIV,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int             IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 timer_load;
    logic                 timer_expire;

    uart_tx_bit_timer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .en_i     (state_q != IDLE),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (tx_valid) begin
                    shift_d    = tx_data;
                    state_d    = START;
                    tx_d       = 1'b0;
                    timer_load = 1'b1;
                end
            end
            START: begin
                if (timer_expire) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                // The line is driven from shift_q[1] since the shift lands on the same edge.
                if (timer_expire) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = STOP;
                        tx_d      = IDLE_LEVEL;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (timer_expire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_ready = (state_q == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// tb_uart_tx : directed self-checking bench for uart_tx (BAUD_DIV 4 and 2)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       tx2;
    logic       tx_busy2;
    logic       tx_done2;

    int tests;
    int fails;

    uart_tx #(.BAUD_DIV(4), .DATA_BITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    uart_tx #(.BAUD_DIV(2), .DATA_BITS(8)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx       (tx2),
        .tx_busy  (tx_busy2),
        .tx_done  (tx_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Frame bit j: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        return 1'b1;
    endfunction

    // Entered one step after the handshake edge; leaves one step after the tx_done edge.
    task automatic run_frame(input logic [7:0] d, input int inj_on, input int inj_off);
        check($sformatf("start_tx_%02h", d), tx, 1'b0);
        check($sformatf("start_busy_%02h", d), tx_busy, 1'b1);
        check($sformatf("start_ready_%02h", d), tx_ready, 1'b0);
        for (int m = 1; m <= 40; m++) begin
            tick();
            if (m == inj_on) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
                check($sformatf("busy_ready_%02h", d), tx_ready, 1'b0);
            end
            if (m == inj_off) tx_valid = 1'b0;
            if (m < 40 && (m % 4) == 2) begin
                check($sformatf("bit%0d_%02h", m / 4, d), tx, frame_bit(d, m / 4));
                check($sformatf("nodone%0d_%02h", m, d), tx_done, 1'b0);
                check($sformatf("busy%0d_%02h", m, d), tx_busy, 1'b1);
            end
            if (m == 39) check($sformatf("done_early_%02h", d), tx_done, 1'b0);
        end
        check($sformatf("done_%02h", d), tx_done, 1'b1);
        check($sformatf("end_ready_%02h", d), tx_ready, 1'b1);
        check($sformatf("end_busy_%02h", d), tx_busy, 1'b0);
        check($sformatf("end_tx_%02h", d), tx, 1'b1);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 8'h00;
        tx_valid2 = 1'b0;

        // Reset values, then a long idle stretch.
        tick();
        tick();
        check("rst_tx", tx, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_tx", tx, 1'b1);
            check("idle_ready", tx_ready, 1'b1);
            check("idle_busy", tx_busy, 1'b0);
            check("idle_done", tx_done, 1'b0);
        end

        // Single frame 0xA5.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        run_frame(8'hA5, 0, 0);
        tick();
        check("done_pulse_A5", tx_done, 1'b0);

        // Back-to-back with tx_valid held; data changes mid-frame are ignored.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hFF;
        run_frame(8'h00, 0, 0);
        tick();
        tx_valid = 1'b0;
        check("b2b_done_clr", tx_done, 1'b0);
        run_frame(8'hFF, 0, 0);
        tick();

        // Request while busy is dropped, not queued.
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        run_frame(8'h55, 10, 30);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_3C_tx", tx, 1'b1);
            check("no_3C_busy", tx_busy, 1'b0);
        end

        // Asynchronous reset during data bit 3 of 0x81.
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int m = 1; m <= 18; m++) tick();
        check("pre_rst_bit3", tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_busy", tx_busy, 1'b0);
        check("async_rst_ready", tx_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_done", tx_done, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_tx", tx, 1'b1);
            check("post_rst_done", tx_done, 1'b0);
        end
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        run_frame(8'h81, 0, 0);
        tick();

        // BAUD_DIV=2 instance: every bit two cycles, done 20 cycles after handshake.
        tx_data2  = 8'h01;
        tx_valid2 = 1'b1;
        tick();
        tx_valid2 = 1'b0;
        for (int m = 0; m < 20; m++) begin
            if (m > 0) tick();
            check($sformatf("b2_bit_m%0d", m), tx2, frame_bit(8'h01, m / 2));
            check($sformatf("b2_nodone_m%0d", m), tx_done2, 1'b0);
        end
        tick();
        check("b2_done", tx_done2, 1'b1);
        check("b2_ready", tx_ready2, 1'b1);
        tick();
        check("b2_done_clr", tx_done2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
